// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register ids, write masks, vectors,
// exception codes and Status/Cause field layouts.
package cp0_pkg;

    typedef enum logic [3:0] {
        CP0_BADVADDR = 4'd1,
        CP0_COUNT    = 4'd2,
        CP0_COMPARE  = 4'd3,
        CP0_STATUS   = 4'd4,
        CP0_CAUSE    = 4'd5,
        CP0_EPC      = 4'd6,
        CP0_PRID     = 4'd7,
        CP0_CONFIG   = 4'd8,
        CP0_CONFIG1  = 4'd9,
        CP0_ERROREPC = 4'd10
    } cprid_t;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12
    } exc_code_t;

    localparam logic [31:0] MASK_STATUS  = 32'h0040_FF07;
    localparam logic [31:0] MASK_CAUSE   = 32'h0000_0300;
    localparam logic [31:0] MASK_FULL    = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_NONE    = 32'h0000_0000;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0004;

    localparam logic [31:0] VEC_BOOT     = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORMAL   = 32'h8000_0180;

    typedef struct packed {
        logic [8:0] rsv_hi;
        logic       bev;
        logic [5:0] rsv_mid;
        logic [7:0] im;
        logic [4:0] rsv_lo;
        logic       erl;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic [14:0] rsv_hi;
        logic [7:0]  ip;
        logic        rsv_mid;
        logic [4:0]  exc_code;
        logic [1:0]  rsv_lo;
    } cause_t;

    function automatic logic [31:0] apply_mask(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [31:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with half-rate tick and sticky timer interrupt.
// TI is registered from the pre-update Count/Compare comparison.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick    <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            tick <= ~tick;
            if (count_we)
                count <= apply_mask(count, wdata, MASK_FULL);
            else if (tick)
                count <= count + 32'd1;
            // a Compare write acknowledges the interrupt, even on a match
            if (compare_we) begin
                compare <= apply_mask(compare, wdata, MASK_FULL);
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file owner: MTC0/MFC0, exception entry, ERET,
// timer and interrupt request, with registered redirect.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE    = 32'h0001_8000,
    parameter logic [31:0] CONFIG_VALUE  = 32'h8000_0000,
    parameter logic [31:0] CONFIG1_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mt_valid,
    input  logic [3:0]  mt_id,
    input  logic [31:0] mt_data,
    input  logic [3:0]  mf_id,
    output logic [31:0] mf_data,
    input  logic        ex_valid,
    input  logic [4:0]  ex_code,
    input  logic        ex_bd,
    input  logic [31:0] ex_pc,
    input  logic        ex_badva_valid,
    input  logic [31:0] ex_badva,
    input  logic        eret_valid,
    input  logic [5:0]  ext_int,
    output logic        int_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    status_t     status_q;
    cause_t      cause_q;
    cause_t      cause_rd;
    logic [5:0]  ip_hw_q;
    logic [31:0] epc_q;
    logic [31:0] badva_q;
    logic [31:0] errorepc_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    logic do_eret;
    logic do_mt;

    assign do_eret = eret_valid & ~ex_valid;
    assign do_mt   = mt_valid & ~ex_valid & ~eret_valid;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (do_mt && (mt_id == CP0_COUNT)),
        .compare_we (do_mt && (mt_id == CP0_COMPARE)),
        .wdata      (mt_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q       <= status_t'(STATUS_RESET);
            cause_q        <= '0;
            ip_hw_q        <= '0;
            epc_q          <= '0;
            badva_q        <= '0;
            errorepc_q     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            ip_hw_q        <= ext_int;
            redirect_valid <= ex_valid | do_eret;
            if (ex_valid) begin
                // nested exceptions keep the original return point
                if (!status_q.exl) begin
                    epc_q      <= ex_bd ? ex_pc - 32'd4 : ex_pc;
                    cause_q.bd <= ex_bd;
                end
                cause_q.exc_code <= ex_code;
                status_q.exl     <= 1'b1;
                if (ex_badva_valid)
                    badva_q <= ex_badva;
                redirect_pc <= status_q.bev ? VEC_BOOT : VEC_NORMAL;
            end else if (do_eret) begin
                if (status_q.erl) begin
                    status_q.erl <= 1'b0;
                    redirect_pc  <= errorepc_q;
                end else begin
                    status_q.exl <= 1'b0;
                    redirect_pc  <= epc_q;
                end
            end else if (do_mt) begin
                unique case (1'b1)
                    (mt_id == CP0_STATUS):
                        status_q <= status_t'(apply_mask(
                            status_q, mt_data, MASK_STATUS));
                    (mt_id == CP0_CAUSE):
                        cause_q <= cause_t'(apply_mask(
                            cause_q, mt_data, MASK_CAUSE));
                    (mt_id == CP0_EPC):
                        epc_q <= apply_mask(epc_q, mt_data, MASK_FULL);
                    (mt_id == CP0_ERROREPC):
                        errorepc_q <= apply_mask(
                            errorepc_q, mt_data, MASK_FULL);
                    (mt_id == CP0_BADVADDR):
                        badva_q <= apply_mask(badva_q, mt_data, MASK_NONE);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cause_rd         = cause_q;
        cause_rd.ip[7]   = ti | ip_hw_q[5];
        cause_rd.ip[6:2] = ip_hw_q[4:0];
    end

    assign int_req = status_q.ie & ~status_q.exl & ~status_q.erl &
                     (|(cause_rd.ip & status_q.im));

    always_comb begin
        mf_data = '0;
        unique case (1'b1)
            (mf_id == CP0_BADVADDR): mf_data = badva_q;
            (mf_id == CP0_COUNT):    mf_data = count;
            (mf_id == CP0_COMPARE):  mf_data = compare;
            (mf_id == CP0_STATUS):   mf_data = status_q;
            (mf_id == CP0_CAUSE):    mf_data = cause_rd;
            (mf_id == CP0_EPC):      mf_data = epc_q;
            (mf_id == CP0_PRID):     mf_data = PRID_VALUE;
            (mf_id == CP0_CONFIG):   mf_data = CONFIG_VALUE;
            (mf_id == CP0_CONFIG1):  mf_data = CONFIG1_VALUE;
            (mf_id == CP0_ERROREPC): mf_data = errorepc_q;
            default:                 mf_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Randomized self-checking bench for cp0_unit against a
// register-level behavioural model, plus literal anchor checks.
module tb_cp0_unit;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mt_valid = 1'b0;
    logic [3:0]  mt_id = '0;
    logic [31:0] mt_data = '0;
    logic [3:0]  mf_id = '0;
    logic [31:0] mf_data;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_code = '0;
    logic        ex_bd = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_badva_valid = 1'b0;
    logic [31:0] ex_badva = '0;
    logic        eret_valid = 1'b0;
    logic [5:0]  ext_int = '0;
    logic        int_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #10 clk = ~clk;

    cp0_unit dut (
        .clk            (clk),
        .reset          (reset),
        .mt_valid       (mt_valid),
        .mt_id          (mt_id),
        .mt_data        (mt_data),
        .mf_id          (mf_id),
        .mf_data        (mf_data),
        .ex_valid       (ex_valid),
        .ex_code        (ex_code),
        .ex_bd          (ex_bd),
        .ex_pc          (ex_pc),
        .ex_badva_valid (ex_badva_valid),
        .ex_badva       (ex_badva),
        .eret_valid     (eret_valid),
        .ext_int        (ext_int),
        .int_req        (int_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // ---------------- behavioural model ----------------
    bit          m_ok = 0;
    int unsigned m_edges;
    logic [31:0] m_status, m_epc, m_badva, m_errorepc;
    logic [31:0] m_count, m_compare;
    logic        m_ti, m_bd;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_ext;
    logic        m_rv;
    logic [31:0] m_rpc;

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = '0;
        c[31]    = m_bd;
        c[15]    = m_ti | m_ext[5];
        c[14:10] = m_ext[4:0];
        c[9:8]   = m_ipsw;
        c[6:2]   = m_exc;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] id);
        case (id)
            4'd1:  return m_badva;
            4'd2:  return m_count;
            4'd3:  return m_compare;
            4'd4:  return m_status;
            4'd5:  return m_cause();
            4'd6:  return m_epc;
            4'd7:  return 32'h0001_8000;
            4'd8:  return 32'h8000_0000;
            4'd9:  return 32'h0000_0000;
            4'd10: return m_errorepc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_int();
        logic [31:0] c;
        c = m_cause();
        return m_status[0] && !m_status[1] && !m_status[2] &&
               ((c[15:8] & m_status[15:8]) != 8'h0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1;
            m_edges = 0;
            m_status = 32'h0040_0004;
            m_epc = 0; m_badva = 0; m_errorepc = 0;
            m_count = 0; m_compare = 0; m_ti = 0;
            m_bd = 0; m_exc = 0; m_ipsw = 0; m_ext = 0;
            m_rv = 0; m_rpc = 0;
        end else begin
            logic        hit, wr_mt, wr_er;
            logic [31:0] nxt_count;
            hit   = (m_count == m_compare);
            wr_er = eret_valid && !ex_valid;
            wr_mt = mt_valid && !ex_valid && !eret_valid;
            // Count advances on every second cycle after reset
            nxt_count = (m_edges % 2 == 1) ? m_count + 1 : m_count;
            if (hit) m_ti = 1;
            m_rv = ex_valid || wr_er;
            if (ex_valid) begin
                if (!m_status[1]) begin
                    m_epc = ex_bd ? ex_pc - 4 : ex_pc;
                    m_bd  = ex_bd;
                end
                m_exc = ex_code;
                if (ex_badva_valid) m_badva = ex_badva;
                m_rpc = m_status[22] ? 32'hBFC0_0380 : 32'h8000_0180;
                m_status[1] = 1;
            end else if (wr_er) begin
                if (m_status[2]) begin
                    m_rpc = m_errorepc;
                    m_status[2] = 0;
                end else begin
                    m_rpc = m_epc;
                    m_status[1] = 0;
                end
            end else if (wr_mt) begin
                case (mt_id)
                    4'd2:  nxt_count = mt_data;
                    4'd3:  begin m_compare = mt_data; m_ti = 0; end
                    4'd4:  m_status = (m_status & ~32'h0040_FF07) |
                                      (mt_data & 32'h0040_FF07);
                    4'd5:  m_ipsw = mt_data[9:8];
                    4'd6:  m_epc = mt_data;
                    4'd10: m_errorepc = mt_data;
                    default: ;
                endcase
            end
            m_count = nxt_count;
            m_ext = ext_int;
            m_edges++;
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            check("mf_data", mf_data, m_read(mf_id));
            check("int_req", {31'b0, int_req}, {31'b0, m_int()});
            check("redirect_valid", {31'b0, redirect_valid},
                  {31'b0, m_rv});
            if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [3:0] id, input logic [31:0] d);
        mt_valid = 1; mt_id = id; mt_data = d;
        step();
        mt_valid = 0;
    endtask

    task automatic rd(input logic [3:0] id, output logic [31:0] v);
        mf_id = id;
        #1;
        v = mf_data;
    endtask

    initial begin
        logic [31:0] v;
        bit found;

        step(); step();
        reset = 0;
        repeat (10) step();
        rd(CP0_COUNT, v);
        check("lit_count_idle", v, 32'd5);
        rd(CP0_STATUS, v);
        check("lit_status_reset", v, 32'h0040_0004);
        check("lit_intreq_reset", {31'b0, int_req}, 32'd0);
        check("lit_redir_reset", {31'b0, redirect_valid}, 32'd0);

        mtc0(CP0_COMPARE, 32'd8);
        mtc0(CP0_COUNT, 32'd6);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            rd(CP0_CAUSE, v);
            if (v[15]) found = 1;
            else step();
        end
        check("lit_ti_rise", {31'b0, found}, 32'd1);
        mtc0(CP0_STATUS, 32'h0000_8001);
        check("lit_intreq_timer", {31'b0, int_req}, 32'd1);
        mtc0(CP0_COMPARE, 32'd20);
        rd(CP0_CAUSE, v);
        check("lit_ti_clear", {31'b0, v[15]}, 32'd0);

        ex_valid = 1; ex_pc = 32'h8000_1004; ex_bd = 1;
        ex_code = EXC_ADEL; ex_badva_valid = 1; ex_badva = 32'h0000_0abc;
        step();
        ex_valid = 0; ex_badva_valid = 0;
        check("lit_ex_rv", {31'b0, redirect_valid}, 32'd1);
        check("lit_ex_rpc", redirect_pc, 32'h8000_0180);
        rd(CP0_EPC, v);
        check("lit_ex_epc", v, 32'h8000_1000);
        rd(CP0_CAUSE, v);
        check("lit_ex_bd", {31'b0, v[31]}, 32'd1);
        rd(CP0_STATUS, v);
        check("lit_ex_exl", {31'b0, v[1]}, 32'd1);
        ex_valid = 1; ex_pc = 32'h9000_0000; ex_bd = 0;
        step();
        ex_valid = 0;
        rd(CP0_EPC, v);
        check("lit_ex_nested_epc", v, 32'h8000_1000);

        mtc0(CP0_ERROREPC, 32'hBFC0_0100);
        mtc0(CP0_STATUS, 32'h0000_0006);
        eret_valid = 1;
        step();
        eret_valid = 0;
        check("lit_eret_erl_rpc", redirect_pc, 32'hBFC0_0100);
        rd(CP0_STATUS, v);
        check("lit_eret_erl_clr", {31'b0, v[2]}, 32'd0);
        eret_valid = 1;
        step();
        eret_valid = 0;
        check("lit_eret_exl_rpc", redirect_pc, 32'h8000_1000);
        rd(CP0_STATUS, v);
        check("lit_eret_exl_clr", {31'b0, v[1]}, 32'd0);

        mtc0(CP0_PRID, 32'hFFFF_FFFF);
        mtc0(CP0_STATUS, 32'hFFFF_FFFF);
        rd(CP0_PRID, v);
        check("lit_prid_ro", v, 32'h0001_8000);
        rd(CP0_STATUS, v);
        check("lit_status_mask", v, 32'h0040_FF07);

        mtc0(CP0_STATUS, 32'h0);
        ex_valid = 1; ex_pc = 32'h8000_2000; ex_bd = 0;
        mt_valid = 1; mt_id = CP0_EPC; mt_data = 32'h1234;
        step();
        ex_valid = 0; mt_valid = 0;
        rd(CP0_EPC, v);
        check("lit_ex_over_mt", v, 32'h8000_2000);

        mtc0(CP0_COMPARE, 32'd1000);
        mtc0(CP0_COUNT, 32'd200);
        mtc0(CP0_COMPARE, 32'd200);
        rd(CP0_CAUSE, v);
        check("lit_cmp_write_wins", {31'b0, v[15]}, 32'd0);

        for (int c = 0; c < 4000; c++) begin
            int unsigned r;
            reset = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 19);
            ex_valid   = (r == 0) || (r == 3);
            eret_valid = (r == 1) || (r == 3);
            mt_valid   = ($urandom_range(0, 2) == 0) || (r == 3);
            mt_id      = 4'($urandom_range(0, 15));
            mt_data    = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                mt_id   = CP0_COMPARE;
                mt_data = m_count + 32'($urandom_range(0, 3));
            end
            ex_code        = 5'($urandom);
            ex_bd          = 1'($urandom);
            ex_pc          = $urandom;
            ex_badva_valid = 1'($urandom);
            ex_badva       = $urandom;
            if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
            mf_id = 4'($urandom_range(0, 15));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
